// File: rtl/mult_err_pkg.sv
// Shared types and widths for the multiplier error-characterisation monitors.
package mult_err_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/mult_err_calc_stage.sv
// Signed error D = P - R_apx, its magnitude AD and an error flag (purely combinational).
module err_calc_stage
  import mult_err_pkg::*;
(
  input  logic        [PROD_W-1:0] p,
  input  logic        [PROD_W-1:0] r_apx,
  output logic signed [PROD_W:0]   d,
  output logic        [PROD_W-1:0] ad,
  output logic                     err
);

  always_comb begin
    d   = $signed({1'b0, p}) - $signed({1'b0, r_apx});
    // |D| fits in PROD_W bits because both operands are PROD_W-bit unsigned.
    ad  = d[PROD_W] ? (~d[PROD_W-1:0] + 1'b1) : d[PROD_W-1:0];
    err = (ad != '0);
  end

endmodule

// File: rtl/mult_err_monitor.sv
// Accumulates error statistics of an 8x8 approximate multiplier over a fixed sample window.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter  int unsigned NUM_SAMPLES = 65536,
  localparam int unsigned CNT_W       = $clog2(NUM_SAMPLES + 1),
  localparam int unsigned SUM_W       = 16 + CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         A,
  input  logic [OP_W-1:0]         B,
  input  logic [PROD_W-1:0]       R_apx,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [SUM_W-1:0]        ed_sum,
  output logic [PROD_W-1:0]       ed_max,
  output logic signed [SUM_W:0]   bias_sum,
  output logic [CNT_W-1:0]        smp_cnt
);

  localparam int unsigned EXT_W = SUM_W - PROD_W;

  state_e             state_q;
  logic [CNT_W-1:0]   acc_q;
  logic               s1_v_q, s2_v_q;
  logic [PROD_W-1:0]  s1_p_q, s1_r_q, s2_p_q, s2_r_q;

  logic               hs;
  logic [PROD_W-1:0]  prod;
  logic [CNT_W-1:0]   acc_nxt;
  logic signed [PROD_W:0] d;
  logic [PROD_W-1:0]  ad;
  logic               err;

  assign hs      = in_valid && in_ready;
  assign prod    = PROD_W'(A) * PROD_W'(B);
  assign acc_nxt = acc_q + 1'b1;

  err_calc_stage u_err_calc (
    .p     (s2_p_q),
    .r_apx (s2_r_q),
    .d     (d),
    .ad    (ad),
    .err   (err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_p_q   <= '0;
      s1_r_q   <= '0;
      s2_p_q   <= '0;
      s2_r_q   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_cnt  <= '0;
      ed_sum   <= '0;
      ed_max   <= '0;
      bias_sum <= '0;
      smp_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // Restart from any state; a handshake in this cycle is dropped.
        state_q  <= StRun;
        acc_q    <= '0;
        s1_v_q   <= 1'b0;
        s2_v_q   <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
        err_cnt  <= '0;
        ed_sum   <= '0;
        ed_max   <= '0;
        bias_sum <= '0;
        smp_cnt  <= '0;
      end else begin
        s1_v_q <= hs;
        if (hs) begin
          s1_p_q <= prod;
          s1_r_q <= R_apx;
        end
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_p_q <= s1_p_q;
          s2_r_q <= s1_r_q;
        end
        if (s2_v_q) begin
          smp_cnt  <= smp_cnt + 1'b1;
          err_cnt  <= err_cnt + CNT_W'(err);
          ed_sum   <= ed_sum + SUM_W'(ad);
          // R_apx - P is -D, sign-extended to the accumulator width.
          bias_sum <= bias_sum - $signed({{EXT_W{d[PROD_W]}}, d});
          if (ad > ed_max) ed_max <= ad;
        end
        unique case (state_q)
          StRun: begin
            if (hs) begin
              acc_q <= acc_nxt;
              if (acc_nxt == CNT_W'(NUM_SAMPLES)) begin
                state_q  <= StDrain;
                in_ready <= 1'b0;
              end
            end
          end
          StDrain: begin
            // S2 drains on this edge, so only S1 needs to be empty.
            if (!s1_v_q) begin
              state_q <= StDone;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
          StIdle, StDone: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_err_monitor.sv
// Self-checking bench for mult_err_monitor: vector table, corner sequences, random windows.
module tb_mult_err_monitor;

  localparam int unsigned N     = 8;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned SUM_W = 16 + CNT_W;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  in_valid = 1'b0;
  logic [7:0]            A = '0;
  logic [7:0]            B = '0;
  logic [15:0]           R_apx = '0;
  logic                  in_ready, busy, done;
  logic [CNT_W-1:0]      err_cnt, smp_cnt;
  logic [SUM_W-1:0]      ed_sum;
  logic [15:0]           ed_max;
  logic signed [SUM_W:0] bias_sum;

  int checks = 0;
  int errors = 0;

  // Reference statistics for the current window.
  longint m_err, m_sum, m_max, m_bias, m_cnt;

  always #5 clk = ~clk;

  mult_err_monitor #(.NUM_SAMPLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .R_apx    (R_apx),
    .busy     (busy),
    .done     (done),
    .err_cnt  (err_cnt),
    .ed_sum   (ed_sum),
    .ed_max   (ed_max),
    .bias_sum (bias_sum),
    .smp_cnt  (smp_cnt)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
    longint      e_err;
    longint      e_sum;
    longint      e_max;
    longint      e_bias;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_err = 0; m_sum = 0; m_max = 0; m_bias = 0; m_cnt = 0;
  endtask

  task automatic model_add(input int a, input int b, input int r);
    longint p, e, ae;
    p  = longint'(a) * longint'(b);
    e  = longint'(r) - p;
    ae = (e < 0) ? -e : e;
    m_cnt++;
    if (ae != 0) m_err++;
    m_sum  += ae;
    m_bias += e;
    if (ae > m_max) m_max = ae;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
  endtask

  // One accepted sample; the DUT must be ready for it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
    chk("in_ready_run", in_ready, 1);
    A = a; B = b; R_apx = r; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_add(a, b, r);
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".smp_cnt"},  smp_cnt,  m_cnt);
    chk({tag, ".err_cnt"},  err_cnt,  m_err);
    chk({tag, ".ed_sum"},   ed_sum,   m_sum);
    chk({tag, ".ed_max"},   ed_max,   m_max);
    chk({tag, ".bias_sum"}, bias_sum, m_bias);
  endtask

  // Called right after the last handshake edge: done must arrive exactly 2 edges later.
  task automatic finish_window(input string tag);
    chk({tag, ".done_early0"}, done, 0);
    chk({tag, ".ready_drain"}, in_ready, 0);
    tick();
    chk({tag, ".done_early1"}, done, 0);
    tick();
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_done"}, busy, 0);
    check_stats(tag);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
  endtask

  initial begin
    tbl[0] = '{a: 8'd15,  b: 8'd15,  r: 16'd225,   e_err: 0, e_sum: 0,      e_max: 0,     e_bias: 0};
    tbl[1] = '{a: 8'd15,  b: 8'd15,  r: 16'd224,   e_err: 8, e_sum: 8,      e_max: 1,     e_bias: -8};
    tbl[2] = '{a: 8'd255, b: 8'd255, r: 16'd0,     e_err: 8, e_sum: 520200, e_max: 65025, e_bias: -520200};
    tbl[3] = '{a: 8'd0,   b: 8'd0,   r: 16'd65535, e_err: 8, e_sum: 524280, e_max: 65535, e_bias: 524280};
    tbl[4] = '{a: 8'd200, b: 8'd3,   r: 16'd700,   e_err: 8, e_sum: 800,    e_max: 100,   e_bias: 800};
    tbl[5] = '{a: 8'd17,  b: 8'd3,   r: 16'd60,    e_err: 8, e_sum: 72,     e_max: 9,     e_bias: 72};

    model_clear();
    tick();
    tick();
    chk("rst.in_ready", in_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.smp_cnt", smp_cnt, 0);
    chk("rst.ed_sum", ed_sum, 0);
    chk("rst.bias_sum", bias_sum, 0);
    rst_n = 1'b1;
    tick();

    // in_valid in IDLE is ignored.
    A = 8'd9; B = 8'd9; R_apx = 16'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle.in_ready", in_ready, 0);
      chk("idle.smp_cnt", smp_cnt, 0);
      chk("idle.busy", busy, 0);
    end
    in_valid = 1'b0;

    // Constant-pattern windows: table expectations computed by hand.
    for (int t = 0; t < 6; t++) begin
      pulse_start();
      chk("tbl.busy", busy, 1);
      for (int i = 0; i < N; i++) send(tbl[t].a, tbl[t].b, tbl[t].r);
      chk("tbl.ready_drain", in_ready, 0);
      tick();
      tick();
      chk("tbl.done", done, 1);
      chk("tbl.smp_cnt", smp_cnt, N);
      chk("tbl.err_cnt", err_cnt, tbl[t].e_err);
      chk("tbl.ed_sum", ed_sum, tbl[t].e_sum);
      chk("tbl.ed_max", ed_max, tbl[t].e_max);
      chk("tbl.bias_sum", bias_sum, tbl[t].e_bias);
      tick();
      chk("tbl.done_pulse", done, 0);
    end

    // in_valid in DONE is ignored and statistics hold.
    A = 8'd255; B = 8'd255; R_apx = 16'd1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_hold.in_ready", in_ready, 0);
      chk("done_hold.smp_cnt", smp_cnt, N);
      chk("done_hold.ed_sum", ed_sum, tbl[5].e_sum);
    end
    in_valid = 1'b0;

    // Extreme single error among exact zero samples.
    pulse_start();
    send(8'd255, 8'd255, 16'd0);
    for (int i = 1; i < N; i++) send(8'd0, 8'd0, 16'd0);
    finish_window("extreme");
    chk("extreme.ed_max_abs", ed_max, 65025);
    chk("extreme.bias_abs", bias_sum, -65025);

    // Restart after 5 of 8: a full new window is needed.
    pulse_start();
    for (int i = 0; i < 5; i++) send(8'd255, 8'd255, 16'd0);
    pulse_start();
    for (int i = 0; i < N - 1; i++) send(8'd1, 8'd1, 16'd0);
    tick();
    tick();
    chk("restart.busy", busy, 1);
    chk("restart.done", done, 0);
    chk("restart.smp_cnt", smp_cnt, N - 1);
    send(8'd1, 8'd1, 16'd0);
    finish_window("restart");

    // Start and handshake in the same cycle: the sample is dropped.
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'd0, 8'd0, 16'd1);
    A = 8'd255; B = 8'd255; R_apx = 16'd0; in_valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    model_clear();
    tick();
    tick();
    chk("collide.smp_cnt", smp_cnt, 0);
    chk("collide.ed_max", ed_max, 0);
    chk("collide.ed_sum", ed_sum, 0);
    for (int i = 0; i < N; i++) send(8'd2, 8'd2, 16'd4);
    finish_window("collide");

    // Randomised windows with idle gaps against the behavioural model.
    for (int w = 0; w < 20; w++) begin
      int acc;
      int k;
      pulse_start();
      acc = 0;
      while (acc < N) begin
        if ($urandom_range(0, 3) != 0) begin
          logic [7:0]  a, b;
          logic [15:0] p, r;
          a = 8'($urandom);
          b = 8'($urandom);
          p = 16'(a) * 16'(b);
          case ($urandom_range(0, 3))
            0:       r = p;
            1:       r = p + 16'($urandom_range(0, 64)) - 16'd32;
            2:       r = 16'($urandom);
            default: r = p & 16'hFFF0;
          endcase
          send(a, b, r);
          acc++;
        end else begin
          tick();
        end
      end
      k = 0;
      while (!done && k < 6) begin
        tick();
        k++;
      end
      chk("rand.done_seen", done, 1);
      check_stats("rand");
    end

    // Reset while draining: everything clears and no done follows.
    pulse_start();
    for (int i = 0; i < N; i++) send(8'd255, 8'd255, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("rstdrain.busy", busy, 0);
    chk("rstdrain.in_ready", in_ready, 0);
    chk("rstdrain.smp_cnt", smp_cnt, 0);
    chk("rstdrain.ed_max", ed_max, 0);
    chk("rstdrain.bias_sum", bias_sum, 0);
    #3;
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rstdrain.no_done", done, 0);
      chk("rstdrain.idle_ready", in_ready, 0);
      chk("rstdrain.idle_smp", smp_cnt, 0);
    end
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_err_monitor.md
Name: mult_err_monitor

Overview:
- Error-characterisation stage placed directly downstream of any 8x8 approximate multiplier in the library.
- Consumes the operand pair and the approximate product, then recomputes the exact product internally.
- Accumulates error statistics over a fixed sample window: error count, sum of absolute error, signed error sum, and maximum absolute error.
- Raises done when the window completes, so MED, bias and error rate can be read out for any library multiplier.

Parameters:
NUM_SAMPLES, 65536, samples per window (1..65536); the default gives an exhaustive 8x8 sweep.
CNT_W, $clog2(NUM_SAMPLES+1), sample and error counter width; derived, not overridden.
SUM_W, 16+CNT_W, absolute-error accumulator width; derived.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear statistics and open a new window
in_valid  in  1  A/B/R_apx valid this cycle
in_ready  out  1  sample accepted when in_valid && in_ready
A  in  8  operand A (unsigned)
B  in  8  operand B (unsigned)
R_apx  in  16  approximate product from the multiplier under test, for the same A/B
busy  out  1  window in progress (RUN or DRAIN)
done  out  1  one-cycle pulse when statistics are final
err_cnt  out  CNT_W  samples with R_apx != A*B
ed_sum  out  SUM_W  sum of |A*B - R_apx|
ed_max  out  16  maximum |A*B - R_apx|
bias_sum  out  SUM_W+1  signed sum of (R_apx - A*B), two's complement
smp_cnt  out  CNT_W  samples accumulated

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs and the pipeline are cleared to 0.
  - in_ready=0; pipeline valid bits=0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE --start--> RUN. Entering RUN clears err_cnt, ed_sum, ed_max, bias_sum, smp_cnt, the accept counter and the pipeline.
  - RUN: in_ready=1. The accept counter increments on each handshake. When the accept counter reaches NUM_SAMPLES on a handshake, go to DRAIN; in_ready is 0 from the next cycle.
  - DRAIN: in_ready=0. Stay until both pipeline stages are empty, then go to DONE and pulse done for exactly one cycle.
  - DONE: statistics are held stable. in_ready=0, busy=0.
  - start in any state (RUN, DRAIN, DONE) is a restart: return to RUN with everything cleared, and any in-flight samples are discarded. A start and a handshake in the same cycle: start wins and that sample is dropped.
- Pipeline (2 stages, valid bit per stage):
  - S1 registers the exact product P=A*B (16b unsigned) and R_apx.
  - S2 computes D=P-R_apx as 17-bit signed and AD=|D| (16b), then updates the statistics registers.
- Latency: a sample accepted at cycle t is reflected in the outputs at the t+2 edge. For a full window, done is high 2 cycles after the last handshake.
- Statistics update per S2-valid sample:
  - smp_cnt += 1
  - err_cnt += (AD != 0)
  - ed_sum += AD
  - bias_sum += (R_apx - P), sign-extended
  - ed_max = max(ed_max, AD)
- Widths are sized so nothing can overflow within NUM_SAMPLES; no saturation logic.
- in_valid while in_ready=0 is ignored; no sample is stored.
- Outputs are registered and stay valid after done until the next start or reset.
- Reset mid-window: all state is lost and the block returns to IDLE; no done is issued.

Decomposition:
- Package mult_err_pkg: state enum (IDLE/RUN/DRAIN/DONE), product width 16, operand width 8.
- Sub-module err_calc_stage: combinational P minus R_apx into signed D, AD and an error flag. It is reused by other library monitors.
- The exact product uses the synthesis multiplier operator; no dependence on library multipliers.

Test Plan:
- Exact feed: NUM_SAMPLES=16, random A/B, R_apx=A*B -> done after 16 handshakes + 2 cycles; err_cnt=0, ed_sum=0, ed_max=0, bias_sum=0, smp_cnt=16.
- Constant offset: NUM_SAMPLES=4, A=B=15, R_apx=224 -> err_cnt=4, ed_sum=4, ed_max=1, bias_sum=-4.
- Extreme: A=B=255, R_apx=0, then A=B=0, R_apx=0 (NUM_SAMPLES=2) -> ed_max=65025, ed_sum=65025, err_cnt=1, bias_sum=-65025.
- Backpressure/idle: in_valid held high in IDLE and DONE -> no count change. Sample and start in the same cycle -> sample dropped, smp_cnt restarts at 0.
- Restart/reset: start after 5 of 8 samples -> 8 new samples required before done. rst_n low mid-DRAIN -> outputs 0, IDLE, no done pulse.
- Exhaustive: NUM_SAMPLES=65536, all A/B pairs, R_apx from a library multiplier under test -> statistics match a golden model exactly; done=1 for one cycle only.
